// File: rtl/traffic_req_pkg.sv
// +----------------------------------------------------------------------------+
// | traffic_pkg : shared state encoding, defaults and light-decode helpers.     |
// | Rev 1.0     : TRAFFIC_REQ_FAULT_EN adds the illegal-light check.            |
// +----------------------------------------------------------------------------+
`default_nettype none

package traffic_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int MIN_GREEN_DEF  = 20;
  localparam int COUNT_W        = 8;

  typedef enum logic [1:0] {
    TRANS = 2'd0,
    N_GO  = 2'd1,
    E_GO  = 2'd2
  } state_t;

  typedef struct packed {
    logic gn;
    logic yn;
    logic rn;
    logic ge;
    logic ye;
    logic re;
  } lights_t;

  // Only the two exact green/red pairings are phases; everything else is TRANS.
  function automatic state_t decode_lights(input lights_t l);
    state_t s;
    case (l)
      6'b100_001: s = N_GO;
      6'b001_100: s = E_GO;
      default:    s = TRANS;
    endcase
    return s;
  endfunction

`ifdef TRAFFIC_REQ_FAULT_EN
  function automatic logic lights_illegal(input lights_t l);
    return (l.gn && l.ge) ||
           !$onehot({l.gn, l.yn, l.rn}) ||
           !$onehot({l.ge, l.ye, l.re});
  endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/traffic_req_if.sv
// +----------------------------------------------------------------------------+
// | traffic_req_if : detectors, light feedback and request outputs.             |
// | Rev 1.0        : FAULT member present only with TRAFFIC_REQ_FAULT_EN.       |
// +----------------------------------------------------------------------------+
`default_nettype none

interface traffic_req_if;
  import traffic_pkg::*;

  logic               CAR_N;
  logic               CAR_E;
  logic               GN;
  logic               YN;
  logic               RN;
  logic               GE;
  logic               YE;
  logic               RE;
  logic               T;
  logic [COUNT_W-1:0] count;
`ifdef TRAFFIC_REQ_FAULT_EN
  logic               FAULT;

  modport master (
    output CAR_N, CAR_E, GN, YN, RN, GE, YE, RE,
    input  T, count, FAULT
  );

  modport slave (
    input  CAR_N, CAR_E, GN, YN, RN, GE, YE, RE,
    output T, count, FAULT
  );
`else
  modport master (
    output CAR_N, CAR_E, GN, YN, RN, GE, YE, RE,
    input  T, count
  );

  modport slave (
    input  CAR_N, CAR_E, GN, YN, RN, GE, YE, RE,
    output T, count
  );
`endif

endinterface

`default_nettype wire

// File: rtl/traffic_req_debounce.sv
// +----------------------------------------------------------------------------+
// | traffic_debounce : run-length debounce of one raw vehicle detector.         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module traffic_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic CLR,
  input  logic raw,
  output logic accepted
);

  localparam int              CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   SAT = CW'(DEB_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      cnt <= '0;
    end else if (!raw) begin
      cnt <= '0;
    end else if (cnt != SAT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign accepted = (cnt == SAT);

endmodule

`default_nettype wire

// File: rtl/traffic_req.sv
// +----------------------------------------------------------------------------+
// | traffic_req : debounced vehicle requests -> registered change request T.    |
// | Rev 1.0     : optional sticky FAULT via TRAFFIC_REQ_FAULT_EN.               |
// +----------------------------------------------------------------------------+
`default_nettype none

module traffic_req
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MIN_GREEN  = MIN_GREEN_DEF
) (
  input  logic         CLK,
  input  logic         CLR,
  traffic_req_if.slave bus
);

  localparam logic [COUNT_W-1:0] COUNT_MAX    = '1;
  localparam logic [COUNT_W-1:0] GREEN_THRESH = COUNT_W'(MIN_GREEN - 1);

  logic               acc_n;
  logic               acc_e;
  lights_t            lights_q;
  state_t             state;
  state_t             state_next;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_next;
  logic               req_n;
  logic               req_e;
  logic               req_n_next;
  logic               req_e_next;
  logic               t_q;
  logic               t_next;
  logic               t_final;

  traffic_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_n (
    .CLK      (CLK),
    .CLR      (CLR),
    .raw      (bus.CAR_N),
    .accepted (acc_n)
  );

  traffic_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_e (
    .CLK      (CLK),
    .CLR      (CLR),
    .raw      (bus.CAR_E),
    .accepted (acc_e)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      lights_q <= '0;
    end else begin
      lights_q <= '{gn: bus.GN, yn: bus.YN, rn: bus.RN,
                    ge: bus.GE, ye: bus.YE, re: bus.RE};
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= TRANS;
    end else begin
      state <= state_next;
    end
  end

  // count, the request latches and T are all computed against state_next so
  // they line up with the state register: count reads 0 in a phase's first
  // cycle and T drops in the same cycle the FSM reaches TRANS.
  always_comb begin
    state_next = decode_lights(lights_q);
    count_next = '0;
    req_n_next = req_n;
    req_e_next = req_e;
    t_next     = 1'b0;

    if (state_next != TRANS && state_next == state) begin
      count_next = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
    end

    if (state == N_GO && acc_e) begin
      req_e_next = 1'b1;
    end
    if (state == E_GO && acc_n) begin
      req_n_next = 1'b1;
    end
    if (state_next == E_GO && state != E_GO) begin
      req_e_next = 1'b0;
    end
    if (state_next == N_GO && state != N_GO) begin
      req_n_next = 1'b0;
    end

    t_next = ((state_next == N_GO && req_e) || (state_next == E_GO && req_n)) &&
             (count_next >= GREEN_THRESH);
  end

`ifdef TRAFFIC_REQ_FAULT_EN
  logic lights_vld;
  logic fault_q;
  logic fault_next;

  // lights_q holds reset zeros for one cycle; those are not a real sample.
  assign fault_next = fault_q | (lights_vld & lights_illegal(lights_q));
  assign t_final    = t_next & ~fault_next;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      lights_vld <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      lights_vld <= 1'b1;
      fault_q    <= fault_next;
    end
  end

  assign bus.FAULT = fault_q;
`else
  assign t_final = t_next;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      count_q <= '0;
      req_n   <= 1'b0;
      req_e   <= 1'b0;
      t_q     <= 1'b0;
    end else begin
      count_q <= count_next;
      req_n   <= req_n_next;
      req_e   <= req_e_next;
      t_q     <= t_final;
    end
  end

  assign bus.T     = t_q;
  assign bus.count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_req.sv
// Directed bench for traffic_req: reset, count saturation, debounce rejection,
// min-green timing, late request latency, phase change and mid-phase reset.
`default_nettype none

module tb_traffic_req;

  localparam logic [5:0] L_OFF  = 6'b000_000;
  localparam logic [5:0] L_NGO  = 6'b100_001;
  localparam logic [5:0] L_EGO  = 6'b001_100;
  localparam logic [5:0] L_YN   = 6'b010_001;
  localparam logic [5:0] L_GNGE = 6'b100_100;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  traffic_req_if bus ();

  traffic_req dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lights(input logic [5:0] v);
    {bus.GN, bus.YN, bus.RN, bus.GE, bus.YE, bus.RE} = v;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    bus.CAR_N = 1'b0;
    bus.CAR_E = 1'b0;
    set_lights(L_OFF);
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_lights(L_NGO);
    bus.CAR_E = 1'b1;
    repeat (30) tick();
    clr = 1'b1;
    tick();
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL reset_T got=%b exp=0", bus.T); end
    n_cmp++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_cmp++; if (dut.req_e !== 1'b0) begin n_err++; $display("FAIL reset_req_e got=%b exp=0", dut.req_e); end
    n_cmp++; if (dut.req_n !== 1'b0) begin n_err++; $display("FAIL reset_req_n got=%b exp=0", dut.req_n); end
    n_cmp++; if (dut.state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
    clr = 1'b0;
    bus.CAR_E = 1'b0;
  endtask

  task automatic test_count_sat();
    int exp_c;
    do_reset();
    set_lights(L_NGO);
    for (int i = 1; i <= 262; i++) begin
      tick();
      exp_c = (i < 2) ? 0 : ((i - 2 > 255) ? 255 : i - 2);
      n_cmp++;
      if (bus.count !== 8'(exp_c)) begin
        n_err++; $display("FAIL count_sat i=%0d got=%0d exp=%0d", i, bus.count, exp_c);
      end
      n_cmp++;
      if (bus.T !== 1'b0) begin
        n_err++; $display("FAIL count_sat_T i=%0d got=%b exp=0", i, bus.T);
      end
    end
  endtask

  task automatic test_short_pulse();
    do_reset();
    set_lights(L_NGO);
    tick(); tick();
    bus.CAR_E = 1'b1;
    repeat (3) tick();
    bus.CAR_E = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_cmp++;
      if (bus.T !== 1'b0 || dut.req_e !== 1'b0) begin
        n_err++; $display("FAIL short_pulse i=%0d T=%b req_e=%b exp=0/0", i, bus.T, dut.req_e);
      end
    end
  endtask

  task automatic test_min_green();
    logic exp_t;
    do_reset();
    set_lights(L_NGO);
    tick(); tick();
    n_cmp++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL mg_first got=%0d exp=0", bus.count); end
    tick(); tick();
    bus.CAR_E = 1'b1;
    for (int k = 3; k <= 30; k++) begin
      tick();
      exp_t = (k >= 19);
      n_cmp++;
      if (bus.count !== 8'(k)) begin n_err++; $display("FAIL mg_count k=%0d got=%0d exp=%0d", k, bus.count, k); end
      n_cmp++;
      if (bus.T !== exp_t) begin n_err++; $display("FAIL mg_T k=%0d got=%b exp=%b", k, bus.T, exp_t); end
    end
    set_lights(L_YN);
    tick();
    n_cmp++; if (bus.T !== 1'b1) begin n_err++; $display("FAIL yel_reg_T got=%b exp=1", bus.T); end
    tick();
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL yel_T got=%b exp=0", bus.T); end
    n_cmp++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL yel_count got=%0d exp=0", bus.count); end
    set_lights(L_EGO);
    tick();
    n_cmp++; if (dut.req_e !== 1'b1) begin n_err++; $display("FAIL trans_req_e got=%b exp=1", dut.req_e); end
    tick();
    n_cmp++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL ego_count got=%0d exp=0", bus.count); end
    n_cmp++; if (dut.req_e !== 1'b0) begin n_err++; $display("FAIL ego_req_e got=%b exp=0", dut.req_e); end
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL ego_T got=%b exp=0", bus.T); end
    repeat (25) tick();
    n_cmp++; if (dut.req_e !== 1'b0) begin n_err++; $display("FAIL green_ignore got=%b exp=0", dut.req_e); end
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL green_ignore_T got=%b exp=0", bus.T); end
    bus.CAR_E = 1'b0;
  endtask

  task automatic test_late_request();
    do_reset();
    set_lights(L_NGO);
    tick(); tick();
    repeat (19) tick();
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL late_noreq_T got=%b exp=0", bus.T); end
    tick();
    bus.CAR_E = 1'b1;
    repeat (4) tick();
    n_cmp++; if (dut.req_e !== 1'b0) begin n_err++; $display("FAIL late_req24 got=%b exp=0", dut.req_e); end
    tick();
    n_cmp++; if (dut.req_e !== 1'b1) begin n_err++; $display("FAIL late_req25 got=%b exp=1", dut.req_e); end
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL late_T25 got=%b exp=0", bus.T); end
    tick();
    n_cmp++; if (bus.T !== 1'b1) begin n_err++; $display("FAIL late_T26 got=%b exp=1", bus.T); end
    bus.CAR_E = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_lights(L_EGO);
    bus.CAR_N = 1'b1;
    tick(); tick();
    repeat (10) tick();
    n_cmp++; if (bus.count !== 8'd10) begin n_err++; $display("FAIL mr_count10 got=%0d exp=10", bus.count); end
    n_cmp++; if (dut.req_n !== 1'b1) begin n_err++; $display("FAIL mr_req_n10 got=%b exp=1", dut.req_n); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL mr_T got=%b exp=0", bus.T); end
    n_cmp++; if (dut.req_n !== 1'b0) begin n_err++; $display("FAIL mr_req_n got=%b exp=0", dut.req_n); end
    n_cmp++; if (bus.count !== 8'd0) begin n_err++; $display("FAIL mr_count got=%0d exp=0", bus.count); end
    tick(); tick(); tick();
    n_cmp++; if (bus.count !== 8'd1) begin n_err++; $display("FAIL mr_restart got=%0d exp=1", bus.count); end
    tick();
    n_cmp++; if (dut.req_n !== 1'b0) begin n_err++; $display("FAIL mr_fresh15 got=%b exp=0", dut.req_n); end
    tick();
    n_cmp++; if (dut.req_n !== 1'b1) begin n_err++; $display("FAIL mr_fresh16 got=%b exp=1", dut.req_n); end
    n_cmp++; if (bus.count !== 8'd3) begin n_err++; $display("FAIL mr_count16 got=%0d exp=3", bus.count); end
    bus.CAR_N = 1'b0;
  endtask

`ifdef TRAFFIC_REQ_FAULT_EN
  task automatic test_fault();
    do_reset();
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_err++; $display("FAIL fault_rst got=%b exp=0", bus.FAULT); end
    set_lights(L_NGO);
    repeat (4) tick();
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_err++; $display("FAIL fault_legal got=%b exp=0", bus.FAULT); end
    set_lights(L_GNGE);
    tick();
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_err++; $display("FAIL fault_early got=%b exp=0", bus.FAULT); end
    tick();
    n_cmp++; if (bus.FAULT !== 1'b1) begin n_err++; $display("FAIL fault_set got=%b exp=1", bus.FAULT); end
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL fault_T got=%b exp=0", bus.T); end
    set_lights(L_NGO);
    bus.CAR_E = 1'b1;
    repeat (30) tick();
    n_cmp++; if (bus.FAULT !== 1'b1) begin n_err++; $display("FAIL fault_sticky got=%b exp=1", bus.FAULT); end
    n_cmp++; if (bus.T !== 1'b0) begin n_err++; $display("FAIL fault_T_forced got=%b exp=0", bus.T); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (bus.FAULT !== 1'b0) begin n_err++; $display("FAIL fault_clr got=%b exp=0", bus.FAULT); end
    bus.CAR_E = 1'b0;
  endtask
`endif

  initial begin
    bus.CAR_N = 1'b0;
    bus.CAR_E = 1'b0;
    set_lights(L_OFF);
    test_reset();
    test_count_sat();
    test_short_pulse();
    test_min_green();
    test_late_request();
    test_mid_reset();
`ifdef TRAFFIC_REQ_FAULT_EN
    test_fault();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
